// File: rtl/mips_data_mem.sv
// Data-side memory for the pipelined MIPS CPU: word-organised RAM with byte-lane
// writes, plus an MMIO window holding a cycle counter and a byte-wide TX FIFO.
module mips_data_mem #(
    parameter int RAM_ADDR_W = 10,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_WORDS = 2 ** RAM_ADDR_W;
    localparam int unsigned DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        MMIO_CYCLE  = 2'd0,
        MMIO_TXDATA = 2'd1,
        MMIO_STATUS = 2'd2,
        MMIO_RSVD   = 2'd3
    } mmio_sel_e;

    logic [31:0]           ram [RAM_WORDS];
    logic [RAM_ADDR_W-1:0] word_idx;
    logic                  is_mmio;
    logic                  any_we;
    mmio_sel_e             mmio_sel;

    logic [31:0]           cycle_cnt;

    logic [7:0]            fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW-1:0]    rd_ptr_next;
    logic [FIFO_AW:0]      count;
    logic [FIFO_AW:0]      count_next;
    logic                  overflow;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  status_wr;
    logic [7:0]            head_next;

    logic [31:0]           status_word;
    logic [31:0]           mmio_rdata;
    logic [31:0]           rdata_next;

    // Address bits above the RAM index and the byte offset play no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[30:RAM_ADDR_W+2], mem_addr[1:0]};

    assign word_idx = mem_addr[RAM_ADDR_W+1:2];
    assign is_mmio  = mem_addr[31];
    assign mmio_sel = mmio_sel_e'(mem_addr[3:2]);
    assign any_we   = |mem_write_en;

    always_ff @(posedge clk) begin
        if (en && !is_mmio) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_write_en[i]) begin
                    ram[word_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
                end
            end
        end
    end

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    always_comb begin
        status_word                = '0;
        status_word[0]             = fifo_full;
        status_word[1]             = fifo_empty;
        status_word[2]             = overflow;
        status_word[FIFO_AW+8:8]   = count;
    end

    always_comb begin
        mmio_rdata = '0;
        unique case (mmio_sel)
            MMIO_CYCLE:  mmio_rdata = cycle_cnt;
            MMIO_TXDATA: mmio_rdata = '0;
            MMIO_STATUS: mmio_rdata = status_word;
            MMIO_RSVD:   mmio_rdata = '0;
        endcase
    end

    // RAM is sampled before this edge's write lands, giving read-first behaviour.
    assign rdata_next = is_mmio ? mmio_rdata : ram[word_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_data <= '0;
        end else if (en && mem_read_en) begin
            mem_read_data <= rdata_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (en) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign pop       = tx_valid && tx_ready;
    assign push_req  = en && is_mmio && (mmio_sel == MMIO_TXDATA) && any_we;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign status_wr = en && is_mmio && (mmio_sel == MMIO_STATUS) && any_we;

    always_comb begin
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_next = count + (FIFO_AW + 1)'(1);
            2'b01:   count_next = count - (FIFO_AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    // Registered head: the byte landing in the new head slot this edge must come
    // straight from the store data since the storage write is not yet visible.
    always_comb begin
        head_next = fifo_mem[rd_ptr_next];
        if (push_ok && (wr_ptr == rd_ptr_next)) begin
            head_next = mem_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            tx_valid <= (count_next != '0);
            tx_data  <= head_next;
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (status_wr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem: directed scenarios plus randomized
// traffic compared against a queue/array reference model.
module tb_mips_data_mem;

    localparam int RAM_ADDR_W = 10;
    localparam int FIFO_AW    = 3;
    localparam int DEPTH      = 8;
    localparam int RAM_WORDS  = 1024;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_RSVD   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    always #5 clk = ~clk;

    mips_data_mem #(
        .RAM_ADDR_W(RAM_ADDR_W),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready)
    );

    // Reference model state
    logic [31:0] ram_m   [RAM_WORDS];
    bit          known_m [RAM_WORDS];
    logic [7:0]  q_m [$];
    bit          ovf_m;
    logic [31:0] cyc_m;
    logic [31:0] exp_rd;
    bit          exp_rd_known;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = '0;
        s[0] = (q_m.size() == DEPTH);
        s[1] = (q_m.size() == 0);
        s[2] = ovf_m;
        s[FIFO_AW+8:8] = (FIFO_AW + 1)'(q_m.size());
        return s;
    endfunction

    task automatic model_reset();
        q_m.delete();
        ovf_m        = 1'b0;
        cyc_m        = '0;
        exp_rd       = '0;
        exp_rd_known = 1'b1;
    endtask

    // Drive one cycle (called at a negedge), advance the model, return at the next negedge.
    task automatic step(input bit e, input logic [3:0] we, input bit re,
                        input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        int          idx;
        bit          do_pop;
        logic [31:0] rv;
        bit          rk;
        en             = e;
        mem_write_en   = we;
        mem_read_en    = re;
        mem_addr       = a;
        mem_write_data = wd;
        tx_ready       = rdy;
        idx    = int'(a[RAM_ADDR_W+1:2]);
        do_pop = (q_m.size() != 0) && rdy;
        rk = 1'b1;
        rv = '0;
        if (a[31]) begin
            case (a[3:2])
                2'd0:    rv = cyc_m;
                2'd2:    rv = status_m();
                default: rv = '0;
            endcase
        end else begin
            rv = ram_m[idx];
            rk = known_m[idx];
        end
        if (e && re) begin
            exp_rd       = rv;
            exp_rd_known = rk;
        end
        if (e && !a[31]) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) ram_m[idx][8*i +: 8] = wd[8*i +: 8];
            end
            if (we == 4'hF) known_m[idx] = 1'b1;
        end
        if (do_pop) void'(q_m.pop_front());
        if (e && a[31] && a[3:2] == 2'd1 && we != 4'h0) begin
            if (q_m.size() < DEPTH) q_m.push_back(wd[7:0]);
            else ovf_m = 1'b1;
        end
        if (e && a[31] && a[3:2] == 2'd2 && we != 4'h0) ovf_m = 1'b0;
        if (e) cyc_m = cyc_m + 32'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit e, input bit rdy);
        step(e, 4'h0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; mem_write_en = '0; mem_read_en = 1'b0;
        mem_addr = '0; mem_write_data = '0; tx_ready = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) known_m[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_read_data !== 32'h0) begin
            n_errors++; $display("FAIL reset_rdata: got %h expected %h", mem_read_data, 32'h0);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ram_bytes();
        step(1, 4'hF, 0, 32'h40, 32'h1122_3344, 0);
        step(1, 4'b0100, 0, 32'h41, 32'hAAAA_AAAA, 0);
        step(1, 4'h0, 1, 32'h40, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h11AA_3344) begin
            n_errors++; $display("FAIL ram_byte_merge: got %h expected %h", mem_read_data, 32'h11AA_3344);
        end
        idle(1, 0);
        n_checks++;
        if (mem_read_data !== 32'h11AA_3344) begin
            n_errors++; $display("FAIL ram_read_hold: got %h expected %h", mem_read_data, 32'h11AA_3344);
        end
    endtask

    task automatic test_read_first();
        step(1, 4'hF, 0, 32'h80, 32'h1234_5678, 0);
        step(1, 4'hF, 1, 32'h80, 32'hDEAD_BEEF, 0);
        n_checks++;
        if (mem_read_data !== 32'h1234_5678) begin
            n_errors++; $display("FAIL read_first_old: got %h expected %h", mem_read_data, 32'h1234_5678);
        end
        step(1, 4'h0, 1, 32'h80, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL read_first_new: got %h expected %h", mem_read_data, 32'hDEAD_BEEF);
        end
        step(1, 4'h0, 1, 32'h80 + (32'd4 << RAM_ADDR_W), 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL alias_read: got %h expected %h", mem_read_data, 32'hDEAD_BEEF);
        end
        step(0, 4'hF, 1, 32'h40, 32'h0BAD_F00D, 0);
        n_checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL en_low_rdata: got %h expected %h", mem_read_data, 32'hDEAD_BEEF);
        end
        step(1, 4'h0, 1, 32'h40, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h11AA_3344) begin
            n_errors++; $display("FAIL en_low_ram: got %h expected %h", mem_read_data, 32'h11AA_3344);
        end
    endtask

    task automatic test_counter();
        apply_reset();
        for (int i = 0; i < 4; i++) idle(1, 0);
        step(1, 4'h0, 1, A_CYCLE, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'd4) begin
            n_errors++; $display("FAIL cycle_5th: got %h expected %h", mem_read_data, 32'd4);
        end
        for (int i = 0; i < 3; i++) step(0, 4'h0, 1, A_CYCLE, 32'h0, 0);
        step(1, 4'hF, 1, A_CYCLE, 32'hFFFF_0000, 0);
        n_checks++;
        if (mem_read_data !== 32'd5) begin
            n_errors++; $display("FAIL cycle_frozen: got %h expected %h", mem_read_data, 32'd5);
        end
        en = 1'b0;
        force dut.cycle_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.cycle_cnt;
        cyc_m = 32'hFFFF_FFFD;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(1, 4'h0, 1, A_CYCLE, 32'h0, 0);
            n_checks++;
            if (mem_read_data !== exp_rd) begin
                n_errors++; $display("FAIL cycle_wrap[%0d]: got %h expected %h", i, mem_read_data, exp_rd);
            end
        end
        step(1, 4'h0, 1, A_CYCLE, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'd1) begin
            n_errors++; $display("FAIL cycle_after_wrap: got %h expected %h", mem_read_data, 32'd1);
        end
    endtask

    task automatic test_fifo_overflow();
        for (int i = 1; i <= 9; i++) step(1, 4'hF, 0, A_TXDATA, 32'(i), 0);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
            n_errors++; $display("FAIL fifo_head: got v=%b d=%h expected v=1 d=01", tx_valid, tx_data);
        end
        step(1, 4'h0, 1, A_STATUS, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h0000_0805) begin
            n_errors++; $display("FAIL status_full_ovf: got %h expected %h", mem_read_data, 32'h0000_0805);
        end
        step(1, 4'b0001, 0, A_STATUS, 32'h0, 0);
        step(1, 4'h0, 1, A_STATUS, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h0000_0801) begin
            n_errors++; $display("FAIL status_ovf_clear: got %h expected %h", mem_read_data, 32'h0000_0801);
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                n_errors++; $display("FAIL drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(i));
            end
            idle(1, 1);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_empty: got %b expected 0", tx_valid);
        end
        step(1, 4'h0, 1, A_STATUS, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h0000_0002) begin
            n_errors++; $display("FAIL status_empty: got %h expected %h", mem_read_data, 32'h0000_0002);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b [8];
        exp_b = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        for (int i = 0; i < 8; i++) step(1, 4'hF, 0, A_TXDATA, 32'h11 + 32'(i), 0);
        step(1, 4'hF, 0, A_TXDATA, 32'h55, 1);
        step(1, 4'h0, 1, A_STATUS, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h0000_0801) begin
            n_errors++; $display("FAIL full_push_pop_status: got %h expected %h", mem_read_data, 32'h0000_0801);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                n_errors++; $display("FAIL push_pop_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
            end
            step(0, 4'h0, 0, 32'h0, 32'h0, 1);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL push_pop_empty: got %b expected 0", tx_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) step(1, 4'hF, 0, A_TXDATA, 32'hA1 + 32'(i), 0);
        step(1, 4'h0, 1, 32'h40, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h11AA_3344 || tx_valid !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset: got rd=%h v=%b expected rd=11aa3344 v=1", mem_read_data, tx_valid);
        end
        tx_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_read_data !== 32'h0 || tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL async_reset: got rd=%h v=%b expected rd=0 v=0", mem_read_data, tx_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(1, 1);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_discard: got %b expected 0", tx_valid);
        end
        step(1, 4'h0, 1, 32'h40, 32'h0, 0);
        n_checks++;
        if (mem_read_data !== 32'h11AA_3344) begin
            n_errors++; $display("FAIL ram_survives_reset: got %h expected %h", mem_read_data, 32'h11AA_3344);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  we;
        int          r;
        for (int w = 0; w < 16; w++) step(1, 4'hF, 0, 32'h400 + 32'(4 * w), $urandom, 0);
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            we = 4'h0;
            if (r <= 3) begin
                a       = $urandom;
                a[31]   = 1'b0;
                a[11:2] = 10'(256 + $urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) we = 4'($urandom);
            end else if (r <= 6) begin
                a  = A_TXDATA;
                we = 4'($urandom);
            end else if (r == 7) begin
                a = A_STATUS;
                if ($urandom_range(0, 3) == 0) we = 4'($urandom);
            end else if (r == 8) begin
                a = A_CYCLE;
                we = 4'($urandom);
            end else begin
                a = A_RSVD;
                we = 4'($urandom);
            end
            step($urandom_range(0, 7) != 0, we, 1'($urandom), a, $urandom, 1'($urandom));
            if (exp_rd_known) begin
                n_checks++;
                if (mem_read_data !== exp_rd) begin
                    n_errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, mem_read_data, exp_rd);
                end
            end
            n_checks++;
            if (tx_valid !== (q_m.size() != 0)) begin
                n_errors++; $display("FAIL rand_tx_valid[%0d]: got %b expected %b", n, tx_valid, q_m.size() != 0);
            end
            if (q_m.size() != 0) begin
                n_checks++;
                if (tx_data !== q_m[0]) begin
                    n_errors++; $display("FAIL rand_tx_data[%0d]: got %h expected %h", n, tx_data, q_m[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_bytes();
        test_read_first();
        test_counter();
        test_fifo_overflow();
        test_full_push_pop();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_data_mem.md
# mips_data_mem

Data-side memory system for the pipelined MIPS CPU, the stage directly downstream of the CPU's memory port. It accepts the CPU's per-byte write enables, read enable, address and write data during the X/M boundary and returns read data one cycle later, in time for the M stage. It holds a word-organised data RAM and a small MMIO region: a free-running cycle counter and a byte-wide transmit FIFO with a valid/ready drain port to an external consumer such as a UART.

## Interface
- RAM_ADDR_W, 10: word-address width of the data RAM, giving 2^RAM_ADDR_W words.
- FIFO_AW, 3: log2 of the TX FIFO depth; depth = 2^FIFO_AW, default 8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  CPU-side enable; when low, there are no RAM writes, no FIFO pushes, no read-data update and no counter increment.
- mem_write_en  in  4  byte-lane write enables; [3]=bits 31:24 (address offset 0, big-endian) … [0]=bits 7:0 (offset 3).
- mem_read_en  in  1  load request this cycle.
- mem_addr  in  32  byte address.
- mem_write_data  in  32  store data, already lane-replicated for byte stores.
- mem_read_data  out  32  registered load data; valid the cycle after mem_read_en.
- tx_valid  out  1  FIFO non-empty.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head byte; a pop occurs when tx_valid & tx_ready.

## Operation
- Decode: mem_addr[31]=0 selects RAM; word index = mem_addr[RAM_ADDR_W+1:2]; higher bits are ignored (aliasing). mem_addr[31]=1 selects MMIO, decoded on mem_addr[3:2]:
  - 0x8000_0000 CYCLE: read-only 32-bit counter. Writes are ignored.
  - 0x8000_0004 TXDATA: any write with nonzero mem_write_en pushes mem_write_data[7:0]. Reads return 0.
  - 0x8000_0008 STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[FIFO_AW+8:8] occupancy count, all other bits 0. Any write clears overflow.
  - 0x8000_000C reads 0; writes are ignored.
- RAM write: when en, each lane with mem_write_en[i]=1 updates that byte of the addressed word. Other lanes are untouched.
- Read: when en & mem_read_en, mem_read_data loads the addressed RAM word or MMIO value at the next edge. Otherwise mem_read_data holds its value.
- Read and write to the same RAM word in the same cycle returns the old data (read-first).
- CYCLE increments by 1 each cycle en is high and wraps 0xFFFF_FFFF→0. A read returns the value before that cycle's increment.
- FIFO push is accepted when en, the write targets TXDATA, and either count<depth or a pop occurs in the same cycle. A push to a full FIFO with no pop is dropped and sets overflow.
- FIFO pop is independent of en.
- Simultaneous push and pop leaves count unchanged. On an empty FIFO, a same-cycle push is not visible on tx_data until the next cycle; no bypass.
- Pointers wrap modulo depth. Count has FIFO_AW+1 bits.

## Timing
- Reset values: mem_read_data=0, tx_valid=0, tx_data=0, CYCLE=0, FIFO empty, overflow=0. RAM contents are not reset.
- Load latency is exactly 1 cycle, matching the CPU's M-stage capture of mem_read_data.
- Store latency: the write is visible to a load issued in the following cycle.
- tx_valid and tx_data are registered state, with no combinational path from tx_ready.
- Reset asserted mid-operation empties the FIFO immediately and discards pending bytes. RAM keeps its contents. An in-flight read returns 0.
- While en is low, mem_read_data, CYCLE and RAM are frozen. The FIFO continues to drain.

## Test plan
- Byte/word RAM: sw 0x11223344 to 0x40, then a byte write 0xAA with mem_write_en=0100 to 0x41, then read 0x40 → 0x11AA3344 one cycle after mem_read_en.
- Read-first and aliasing: same-cycle write 0xDEADBEEF and read of 0x80 → old data, next read → 0xDEADBEEF. Reading 0x80 + (4<<RAM_ADDR_W) → 0xDEADBEEF.
- Counter: release reset with en=1; a read of CYCLE issued on the 5th enabled cycle → 4. Drop en for 3 cycles → count frozen. Preload near 0xFFFF_FFFF via force → wraps to 0.
- FIFO fill/overflow with tx_ready=0: 9 pushes 0x01..0x09 → STATUS = full, count 8, overflow=1, 0x09 lost. Write STATUS → overflow=0. Drain with tx_ready=1 → bytes 0x01..0x08 in order, then tx_valid=0.
- Full with simultaneous push and pop: a push of 0x55 accompanied by a pop → accepted, count stays 8, no overflow, 0x55 emerges last.
- Reset mid-drain: assert rst with 3 bytes queued → tx_valid=0 and mem_read_data=0 immediately. RAM word written earlier still reads back after reset.
